instr_encode_loader: RTL and testbench
======================================

Name: instr_encode_loader

Overview:
- Instruction-side producer for the core's decode path. It accepts field-level instruction requests (class, registers, funct bits, immediate) and encodes each one into a 32-bit RV32I instruction word.
- Encoded words are buffered in a small FIFO and written into instruction memory at sequential word addresses.
- Used by boot/self-test logic to place programs that the core's main decoder then consumes.

Parameters:
- ADDR_W, 12, instruction-memory byte-address width.
- BASE_ADDR, 0, byte address of the first word written after start.
- FIFO_DEPTH, 4, encoded-word buffer depth (power of 2, ≥2).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  begin a load session (honoured only in IDLE)
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid & in_ready at posedge clk
- in_last  input  1  marks the final request of the session
- in_cls  input  4  class: 0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC; 9-15 invalid
- in_funct3  input  3  funct3 field
- in_f7b5  input  1  funct7 bit 5 (SUB/SRA/SRAI)
- in_rd, in_rs1, in_rs2  input  5 each  register indices
- in_imm  input  32  immediate (byte offset for B/J; upper 20 bits used for U)
- imem_we  output  1  write request to instruction memory
- imem_addr  output  ADDR_W  byte address, word-aligned
- imem_wdata  output  32  encoded instruction
- imem_ack  input  1  memory accepted the current write
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse when the session completes
- err  output  1  sticky error flag, cleared by an honoured start

Behaviour:
- Reset values: state IDLE, FIFO empty, address = BASE_ADDR, outputs in_ready/imem_we/busy/done/err = 0, imem_wdata = 0.
- FSM states:
  - IDLE: start → RUN; clear err; address ← BASE_ADDR.
  - RUN: accepts requests; an accepted request with in_last → DRAIN.
  - DRAIN: FIFO empty → DONE.
  - DONE: 1 cycle, done=1 → IDLE.
- start outside IDLE is ignored.
- in_ready = (state==RUN) & FIFO not full. in_ready is combinational from registered state; it does not depend on in_valid.
- Encoding is combinational from the in_* fields. The word is pushed into the FIFO at the accepting edge. Minimum latency from acceptance to imem_we is 1 cycle.
- Opcodes and field placement:
  - R 0110011: {0,f7b5,00000, rs2, rs1, f3, rd}.
  - I-ALU 0010011: imm[11:0], rs1, f3, rd. If f3 is 001 or 101, bits[31:25] = {0,f7b5,00000} and bits[24:20] = imm[4:0].
  - LOAD 0000011: I format.
  - STORE 0100011: imm[11:5], rs2, rs1, f3, imm[4:0].
  - BRANCH 1100011: imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11].
  - JAL 1101111: imm[20], imm[10:1], imm[11], imm[19:12], rd.
  - JALR 1100111: imm[11:0], rs1, funct3 forced to 000, rd.
  - LUI 0110111 / AUIPC 0010111: imm[31:12], rd.
- Invalid class: the handshake completes, no word is pushed, err is set. If in_last is set on that request, the FSM still moves to DRAIN.
- Write port:
  - imem_we = FIFO not empty, asserted in RUN or DRAIN.
  - imem_addr and imem_wdata hold stable while imem_we=1 and imem_ack=0.
  - On imem_ack: pop the FIFO and add 4 to the address. The address wraps modulo 2^ADDR_W.
- The FIFO allows a push and a pop in the same cycle when not full. When full, in_ready=0, so no push occurs.
- Reset mid-session: immediate return to the reset values. Buffered words are discarded.

Optional Feature:
- Macro: ENC_IMM_CHECK_EN.
- With the macro defined, a request is flagged out-of-range when:
  - I/LOAD/STORE/JALR: in_imm is not a sign-extended 12-bit value.
  - BRANCH: in_imm is not a sign-extended 13-bit value with bit0=0.
  - JAL: in_imm is not a sign-extended 21-bit value with bit0=0.
  - LUI/AUIPC: in_imm[11:0] != 0.
- An out-of-range request sets err and is dropped, handled like an invalid class.
- Without the macro, there is no range checking and immediate bits are truncated silently.

Test Plan:
- start, then cls1 f3=000 rd=1 rs1=0 imm=5 → imem_wdata 0x00500093 at addr 0x000; cls0 rd=3 rs1=1 rs2=2 f7b5=0 → 0x002081B3 at 0x004; same with f7b5=1 → 0x402081B3 at 0x008.
- cls3 f3=010 rs1=1 rs2=2 imm=8 → 0x0020A423; cls4 f3=000 rs1=1 rs2=2 imm=-4 → 0xFE208EE3; cls5 rd=1 imm=8 → 0x008000EF; cls7 rd=5 imm=0x12345000 → 0x123452B7.
- imem_ack held 0 with FIFO_DEPTH=4 and 6 requests offered → in_ready drops after 4 accepts; addr/wdata stay stable; after imem_ack returns, all 6 words are written in order with addresses incrementing by 4.
- Request cls=12 with in_last=1 → err=1, no write; DRAIN, then done pulses exactly 1 cycle; next start clears err.
- rst asserted while 3 words are buffered → imem_we=0, busy=0 immediately; a new session writes again from BASE_ADDR.
- ENC_IMM_CHECK_EN defined, cls1 imm=0x800 → err=1, no write. Macro undefined → word written with imm field 0x800.

Source files
------------

// File: rtl/instr_encode_loader.sv
// Field-level RV32I instruction encoder feeding a small FIFO that writes words into
// instruction memory at sequential addresses. Optional immediate range checking: ENC_IMM_CHECK_EN.
module instr_encode_loader #(
    parameter int ADDR_W     = 12,
    parameter int BASE_ADDR  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        in_cls,
    input  logic [2:0]        in_funct3,
    input  logic              in_f7b5,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ack,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_nxt;

    logic [31:0]      enc_word;
    logic             cls_ok;
    logic             imm_ok;
    logic             req_ok;
    logic             accept;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic [31:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    // Instruction encoder
    always_comb begin
        enc_word = '0;
        cls_ok   = 1'b1;
        case (in_cls)
            4'd0: enc_word = {1'b0, in_f7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            4'd1: begin
                if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
                    enc_word = {1'b0, in_f7b5, 5'b00000, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
                else
                    enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
            end
            4'd2: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
            4'd3: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
            4'd4: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:1], in_imm[11], 7'b1100011};
            4'd5: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
            4'd6: enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
            4'd7: enc_word = {in_imm[31:12], in_rd, 7'b0110111};
            4'd8: enc_word = {in_imm[31:12], in_rd, 7'b0010111};
            default: cls_ok = 1'b0;
        endcase
    end

`ifdef ENC_IMM_CHECK_EN
    // Upper bits must all equal the sign bit of the encodable field
    always_comb begin
        imm_ok = 1'b1;
        case (in_cls)
            4'd1, 4'd2, 4'd3, 4'd6:
                imm_ok = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
            4'd4:
                imm_ok = ((in_imm[31:12] == '0) || (in_imm[31:12] == '1)) && !in_imm[0];
            4'd5:
                imm_ok = ((in_imm[31:20] == '0) || (in_imm[31:20] == '1)) && !in_imm[0];
            4'd7, 4'd8:
                imm_ok = (in_imm[11:0] == '0);
            default: imm_ok = 1'b1;
        endcase
    end
`else
    assign imm_ok = 1'b1;
`endif

    assign req_ok     = cls_ok & imm_ok;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign in_ready   = (state == RUN) && !fifo_full;
    assign accept     = in_valid && in_ready;
    assign push       = accept && req_ok;
    assign imem_we    = ((state == RUN) || (state == DRAIN)) && !fifo_empty;
    assign pop        = imem_we && imem_ack;
    assign imem_wdata = imem_we ? mem[rd_ptr] : '0;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (accept && in_last) state_nxt = DRAIN;
            DRAIN:   if (fifo_empty) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= enc_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            imem_addr <= ADDR_W'(BASE_ADDR);
        else if (state == IDLE && start)
            imem_addr <= ADDR_W'(BASE_ADDR);
        else if (pop)
            imem_addr <= imem_addr + ADDR_W'(4);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if (state == IDLE && start)
            err <= 1'b0;
        else if (accept && !req_ok)
            err <= 1'b1;
    end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Scoreboard bench for instr_encode_loader: stimulus pushes expected {addr,word},
// a negedge monitor pops and compares on every acknowledged memory write.
module tb_instr_encode_loader;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_last = 1'b0;
    logic [3:0]        in_cls = '0;
    logic [2:0]        in_funct3 = '0;
    logic              in_f7b5 = 1'b0;
    logic [4:0]        in_rd = '0;
    logic [4:0]        in_rs1 = '0;
    logic [4:0]        in_rs2 = '0;
    logic [31:0]       in_imm = '0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              imem_ack = 1'b1;
    logic              busy;
    logic              done;
    logic              err;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [ADDR_W+31:0] exp_q[$];
    logic [ADDR_W-1:0]  exp_addr = '0;

    instr_encode_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_cls(in_cls), .in_funct3(in_funct3), .in_f7b5(in_f7b5),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .imem_ack(imem_ack), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && imem_we && imem_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%03h data 0x%08h expected no write",
                         imem_addr, imem_wdata);
            end else begin
                logic [ADDR_W+31:0] e;
                e = exp_q.pop_front();
                chk("write_addr", 32'(imem_addr), 32'(e[ADDR_W+31:32]));
                chk("write_data", imem_wdata, e[31:0]);
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        exp_addr = '0;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic send(input logic [3:0] cls, input logic [2:0] f3, input logic f7b5,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic last,
                        input logic exp_push, input logic [31:0] exp_word);
        int n;
        in_cls = cls; in_funct3 = f3; in_f7b5 = f7b5; in_rd = rd;
        in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (exp_push) begin
            exp_q.push_back({exp_addr, exp_word});
            exp_addr = exp_addr + ADDR_W'(4);
        end
        #1 in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done), 32'd1);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_after_done", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Basic encodings
        do_start();
        send(4'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5,          1'b0, 1'b1, 32'h00500093);
        send(4'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0,          1'b0, 1'b1, 32'h002081B3);
        send(4'd0, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0,          1'b0, 1'b1, 32'h402081B3);
        send(4'd3, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,          1'b0, 1'b1, 32'h0020A423);
        send(4'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC,   1'b0, 1'b1, 32'hFE208EE3);
        send(4'd5, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8,          1'b0, 1'b1, 32'h008000EF);
        send(4'd1, 3'b101, 1'b1, 5'd4, 5'd2, 5'd0, 32'd3,          1'b0, 1'b1, 32'h40315213);
        send(4'd6, 3'b111, 1'b0, 5'd1, 5'd2, 5'd0, 32'h10,         1'b0, 1'b1, 32'h010100E7);
        send(4'd7, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000,   1'b1, 1'b1, 32'h123452B7);
        wait_done();
        chk("err_clean_session", 32'(err), 32'd0);

        // Back-pressure: memory stalls, FIFO fills after 4 accepts
        imem_ack = 1'b0;
        do_start();
        for (int k = 0; k < 4; k++)
            send(4'd0, 3'b000, 1'b0, 5'(k + 8), 5'd1, 5'd2, 32'd0, 1'b0, 1'b1,
                 32'h00208033 | (32'(k + 8) << 7));
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("stall_we", 32'(imem_we), 32'd1);
        chk("stall_addr", 32'(imem_addr), 32'h000);
        chk("stall_data", imem_wdata, 32'h00208433);
        repeat (3) @(posedge clk);
        #1;
        chk("stall_in_ready_hold", 32'(in_ready), 32'd0);
        chk("stall_addr_hold", 32'(imem_addr), 32'h000);
        chk("stall_data_hold", imem_wdata, 32'h00208433);
        imem_ack = 1'b1;
        send(4'd0, 3'b000, 1'b0, 5'd12, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'h00208633);
        send(4'd0, 3'b000, 1'b0, 5'd13, 5'd1, 5'd2, 32'd0, 1'b1, 1'b1, 32'h002086B3);
        wait_done();

        // Invalid class on the last request
        do_start();
        send(4'd12, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b1, 1'b0, 32'd0);
        chk("err_set_invalid", 32'(err), 32'd1);
        chk("no_write_invalid", 32'(imem_we), 32'd0);
        wait_done();
        chk("err_sticky", 32'(err), 32'd1);
        do_start();
        chk("err_cleared_by_start", 32'(err), 32'd0);

        // Immediate 0x800 on I-ALU
`ifdef ENC_IMM_CHECK_EN
        send(4'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h800, 1'b1, 1'b0, 32'd0);
        chk("imm_range_err", 32'(err), 32'd1);
`else
        send(4'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h800, 1'b1, 1'b1, 32'h80000093);
        chk("imm_trunc_no_err", 32'(err), 32'd0);
`endif
        wait_done();

        // Reset with 3 buffered words
        imem_ack = 1'b0;
        do_start();
        for (int k = 0; k < 3; k++)
            send(4'd1, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'(k), 1'b0, 1'b0, 32'd0);
        chk("buffered_we", 32'(imem_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_we", 32'(imem_we), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_addr", 32'(imem_addr), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        imem_ack = 1'b1;
        do_start();
        send(4'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 1'b1, 32'h00500093);
        wait_done();

        // Address wrap: 1025 writes cover the 4 KiB space and return to 0
        do_start();
        for (int k = 0; k < 1025; k++)
            send(4'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'(k & 32'h7FF), (k == 1024), 1'b1,
                 ((32'(k) & 32'h7FF) << 20) | 32'h00000093);
        wait_done();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
